// File: rtl/custom_ip_reg_sequencer_if.sv
// rtl/custom_ip_reg_sequencer_if.sv - register-side and IP-side bus bundle for custom_ip_reg_sequencer
// Purpose: groups the write/read request bus and the reg2ip/ip2reg IP bus.
// Ports (signals):
//   wr_req_i/wr_data_i/wr_gnt_o   per-word write requests, data, grant pulses
//   rd_req_i/rd_data_o/rd_stale_o/rd_valid_o   readback snapshot
//   ip_data_o/ip_en_o/ip_ack_i/ip_rdata_i      IP reg2ip / ip2reg
//   busy_o/err_timeout_o/clr_err_i             status and sticky error
// Modports: slave = sequencer, master = register block / driver.
interface custom_ip_reg_sequencer_if #(
  parameter int NUM_WORDS  = 3,
  parameter int WORD_WIDTH = 32
);
  logic [NUM_WORDS-1:0]                  wr_req_i;
  logic [NUM_WORDS*WORD_WIDTH-1:0]       wr_data_i;
  logic [NUM_WORDS-1:0]                  wr_gnt_o;
  logic                                  rd_req_i;
  logic [NUM_WORDS*WORD_WIDTH-1:0]       rd_data_o;
  logic [NUM_WORDS-1:0]                  rd_stale_o;
  logic                                  rd_valid_o;
  logic [NUM_WORDS*WORD_WIDTH-1:0]       ip_data_o;
  logic [NUM_WORDS-1:0]                  ip_en_o;
  logic [NUM_WORDS-1:0]                  ip_ack_i;
  logic [NUM_WORDS*(WORD_WIDTH+1)-1:0]   ip_rdata_i;
  logic                                  busy_o;
  logic                                  err_timeout_o;
  logic                                  clr_err_i;

  modport slave (
    input  wr_req_i, wr_data_i, rd_req_i, ip_ack_i, ip_rdata_i, clr_err_i,
    output wr_gnt_o, rd_data_o, rd_stale_o, rd_valid_o, ip_data_o, ip_en_o,
           busy_o, err_timeout_o
  );

  modport master (
    output wr_req_i, wr_data_i, rd_req_i, ip_ack_i, ip_rdata_i, clr_err_i,
    input  wr_gnt_o, rd_data_o, rd_stale_o, rd_valid_o, ip_data_o, ip_en_o,
           busy_o, err_timeout_o
  );
endinterface

// File: rtl/custom_ip_reg_sequencer.sv
// rtl/custom_ip_reg_sequencer.sv - round-robin word-write sequencer and readback snapshot for custom_axi_ip
// Purpose: pushes one 32-bit register word at a time into the IP's reg2ip
//   interface, holding each until acked or timed out, and snapshots ip2reg.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    custom_ip_reg_sequencer_if.slave (see interface file)
module custom_ip_reg_sequencer #(
  parameter int NUM_WORDS  = 3,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  custom_ip_reg_sequencer_if.slave   bus
);
  localparam int N  = NUM_WORDS;
  localparam int W  = WORD_WIDTH;
  localparam int FW = WORD_WIDTH + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_READ} state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q, idx_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     en_q, gnt_q, stale_q;
  logic [N*W-1:0]   data_q, rd_data_q;
  logic             rdv_q, busy_q, err_q, rd_pend_q;

  logic             found_d;
  logic [PW-1:0]    sel_d, ptr_inc_d;
  logic [N-1:0]     en_d;
  logic [N*W-1:0]   data_d;
  logic             ack_hit_d, timeout_d;

  // Round-robin pick: scan ptr, ptr+1, ... with explicit wrap so N need
  // not be a power of two. Inner loop keeps every bit index constant.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      for (int i = 0; i < N; i++) begin
        if (!found_d && (j == i) && bus.wr_req_i[i]) begin
          found_d = 1'b1;
          sel_d   = PW'(i);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      en_d[i] = found_d && (sel_d == PW'(i));
      data_d[(N-1-i)*W +: W] = en_d[i] ? bus.wr_data_i[(N-1-i)*W +: W] : '0;
    end
  end

  // en_q is onehot(idx) while in XFER, so masking avoids a variable select.
  assign ack_hit_d = |(bus.ip_ack_i & en_q);
  assign timeout_d = (state_q == S_XFER) && !ack_hit_d && (cnt_q == CW'(TIMEOUT - 1));
  assign ptr_inc_d = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      gnt_q     <= '0;
      stale_q   <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      rdv_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      gnt_q <= '0;
      rdv_q <= 1'b0;
      // A timeout in the same cycle as a clear keeps the flag set.
      if (timeout_d)          err_q <= 1'b1;
      else if (bus.clr_err_i) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q <= S_XFER;
            en_q    <= en_d;
            data_q  <= data_d;
            idx_q   <= sel_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (bus.rd_req_i) rd_pend_q <= 1'b1;
          end else if (bus.rd_req_i || rd_pend_q) begin
            state_q   <= S_READ;
            busy_q    <= 1'b1;
            rd_pend_q <= 1'b0;
          end
        end
        S_XFER: begin
          if (bus.rd_req_i) rd_pend_q <= 1'b1;
          if (ack_hit_d || timeout_d) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            data_q  <= '0;
            gnt_q   <= en_q;
            ptr_q   <= ptr_inc_d;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_READ: begin
          for (int i = 0; i < N; i++) begin
            rd_data_q[(N-1-i)*W +: W] <= bus.ip_rdata_i[(N-1-i)*FW+1 +: W];
            stale_q[i]                <= ~bus.ip_rdata_i[(N-1-i)*FW];
          end
          rdv_q     <= 1'b1;
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          // A request landing during the READ cycle itself is kept for later.
          rd_pend_q <= bus.rd_req_i;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          en_q    <= '0;
        end
      endcase
    end
  end

  assign bus.wr_gnt_o      = gnt_q;
  assign bus.rd_data_o     = rd_data_q;
  assign bus.rd_stale_o    = stale_q;
  assign bus.rd_valid_o    = rdv_q;
  assign bus.ip_data_o     = data_q;
  assign bus.ip_en_o       = en_q;
  assign bus.busy_o        = busy_q;
  assign bus.err_timeout_o = err_q;
endmodule

// File: tb/tb_custom_ip_reg_sequencer.sv
// tb/tb_custom_ip_reg_sequencer.sv - table-driven self-checking bench for custom_ip_reg_sequencer
module tb_custom_ip_reg_sequencer;
  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  custom_ip_reg_sequencer_if #(.NUM_WORDS(3), .WORD_WIDTH(32)) bus ();

  custom_ip_reg_sequencer #(.NUM_WORDS(3), .WORD_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic        rd;
    logic        clr;
    logic [2:0]  exp_en;
    logic [2:0]  exp_gnt;
    logic        exp_busy;
    logic        exp_err;
    logic        exp_rdv;
    logic [95:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [95:0] WDATA = {32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333};
  localparam logic [95:0] D0 = {32'h1111_1111, 64'h0};
  localparam logic [95:0] D1 = {32'h0, 32'hDEAD_BEEF, 32'h0};
  localparam logic [95:0] D2 = {64'h0, 32'h3333_3333};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] ack,
                      input logic rd, input logic clr);
    @(negedge clk_i);
    rst_i          = rst;
    bus.wr_req_i   = req;
    bus.ip_ack_i   = ack;
    bus.rd_req_i   = rd;
    bus.clr_err_i  = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic [2:0] ack,
                     input logic rd, input logic [2:0] en, input logic [2:0] gnt,
                     input logic busy, input logic rdv, input logic [95:0] data);
    vec_t v;
    v.rst = rst; v.req = req; v.ack = ack; v.rd = rd; v.clr = 1'b0;
    v.exp_en = en; v.exp_gnt = gnt; v.exp_busy = busy; v.exp_err = 1'b0;
    v.exp_rdv = rdv; v.exp_data = data;
    vecs.push_back(v);
  endtask

  initial begin
    int en_cycles;
    int gnts;
    logic done;
    logic [2:0] gnt_val;
    logic err_at_gnt;

    rst_i          = 1'b1;
    bus.wr_req_i   = '0;
    bus.wr_data_i  = WDATA;
    bus.rd_req_i   = 1'b0;
    bus.ip_ack_i   = '0;
    bus.ip_rdata_i = '0;
    bus.clr_err_i  = 1'b0;

    // Reset state
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    check("rst_en",    bus.ip_en_o, 3'b000);
    check("rst_gnt",   bus.wr_gnt_o, 3'b000);
    check("rst_busy",  bus.busy_o, 1'b0);
    check("rst_err",   bus.err_timeout_o, 1'b0);
    check("rst_rdv",   bus.rd_valid_o, 1'b0);
    check("rst_rdata", bus.rd_data_o, 96'h0);
    check("rst_stale", bus.rd_stale_o, 3'b000);
    check("rst_data",  bus.ip_data_o, 96'h0);

    // Single write word1, ack on third XFER cycle
    add(0, 3'b010, 3'b000, 0, 3'b010, 3'b000, 1, 0, D1);
    add(0, 3'b010, 3'b000, 0, 3'b010, 3'b000, 1, 0, D1);
    add(0, 3'b010, 3'b000, 0, 3'b010, 3'b000, 1, 0, D1);
    add(0, 3'b010, 3'b010, 0, 3'b000, 3'b010, 0, 0, 96'h0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 96'h0);
    // Reset to bring ptr back to 0, then round robin with all acks high
    add(1, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 96'h0);
    add(0, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, D0);
    add(0, 3'b111, 3'b111, 0, 3'b000, 3'b001, 0, 0, 96'h0);
    add(0, 3'b111, 3'b111, 0, 3'b010, 3'b000, 1, 0, D1);
    add(0, 3'b111, 3'b111, 0, 3'b000, 3'b010, 0, 0, 96'h0);
    add(0, 3'b111, 3'b111, 0, 3'b100, 3'b000, 1, 0, D2);
    add(0, 3'b111, 3'b111, 0, 3'b000, 3'b100, 0, 0, 96'h0);
    add(0, 3'b111, 3'b111, 0, 3'b001, 3'b000, 1, 0, D0);
    add(0, 3'b111, 3'b111, 0, 3'b000, 3'b001, 0, 0, 96'h0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 96'h0);
    // Read arriving with a write: write first, then read from pending flag
    add(0, 3'b100, 3'b000, 1, 3'b100, 3'b000, 1, 0, D2);
    add(0, 3'b100, 3'b100, 0, 3'b000, 3'b100, 0, 0, 96'h0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1, 0, 96'h0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 1, 96'h0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0, 96'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].ack, vecs[i].rd, vecs[i].clr);
      check($sformatf("v%0d_en", i),   bus.ip_en_o, vecs[i].exp_en);
      check($sformatf("v%0d_gnt", i),  bus.wr_gnt_o, vecs[i].exp_gnt);
      check($sformatf("v%0d_busy", i), bus.busy_o, vecs[i].exp_busy);
      check($sformatf("v%0d_err", i),  bus.err_timeout_o, vecs[i].exp_err);
      check($sformatf("v%0d_rdv", i),  bus.rd_valid_o, vecs[i].exp_rdv);
      check($sformatf("v%0d_data", i), bus.ip_data_o, vecs[i].exp_data);
    end

    // Timeout: word0 never acked
    en_cycles = 0; gnts = 0; done = 1'b0; gnt_val = '0; err_at_gnt = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
      if (bus.ip_en_o == 3'b001) en_cycles++;
      if (bus.wr_gnt_o != 3'b000) begin
        gnts++; gnt_val = bus.wr_gnt_o; err_at_gnt = bus.err_timeout_o; done = 1'b1;
      end
    end
    check("to_gnt_seen",   done, 1'b1);
    check("to_en_cycles",  en_cycles, 16);
    check("to_gnt_val",    gnt_val, 3'b001);
    check("to_err_at_gnt", err_at_gnt, 1'b1);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("to_err_sticky", bus.err_timeout_o, 1'b1);
    check("to_busy_idle",  bus.busy_o, 1'b0);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
    check("to_err_clr",    bus.err_timeout_o, 1'b0);

    // Clear held through a second timeout: the set wins on the exit cycle
    done = 1'b0; err_at_gnt = 1'b0; en_cycles = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(1'b0, 3'b001, 3'b000, 1'b0, 1'b1);
      if (bus.ip_en_o == 3'b001) en_cycles++;
      if (bus.wr_gnt_o != 3'b000) begin
        err_at_gnt = bus.err_timeout_o; done = 1'b1;
      end
    end
    check("to2_gnt_seen",  done, 1'b1);
    check("to2_en_cycles", en_cycles, 16);
    check("to2_err_wins",  err_at_gnt, 1'b1);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("to2_err_kept",  bus.err_timeout_o, 1'b1);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);

    // Readback snapshot, all valid bits 0
    bus.ip_rdata_i = {32'h2468, 1'b0, 32'h369C, 1'b0, 32'h48D0, 1'b0};
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    check("rd_busy", bus.busy_o, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 5 && !done; c++) begin
      step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      if (bus.rd_valid_o) done = 1'b1;
    end
    check("rd_valid_seen", done, 1'b1);
    check("rd_data",  bus.rd_data_o, {32'h2468, 32'h369C, 32'h48D0});
    check("rd_stale", bus.rd_stale_o, 3'b111);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("rd_valid_pulse", bus.rd_valid_o, 1'b0);

    // Readback with word0 and word2 valid
    bus.ip_rdata_i = {32'hA5A5_0001, 1'b1, 32'h5A5A_0002, 1'b0, 32'hC3C3_0003, 1'b1};
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("rd2_valid", bus.rd_valid_o, 1'b1);
    check("rd2_data",  bus.rd_data_o, {32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003});
    check("rd2_stale", bus.rd_stale_o, 3'b010);

    // Reset mid-transfer: no grant, ptr back to 0
    step(1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    check("mr_en_before", bus.ip_en_o, 3'b010);
    step(1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    step(1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
    check("mr_en",   bus.ip_en_o, 3'b000);
    check("mr_busy", bus.busy_o, 1'b0);
    check("mr_gnt",  bus.wr_gnt_o, 3'b000);
    step(1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    check("mr_gnt_after", bus.wr_gnt_o, 3'b000);
    check("mr_first_word0", bus.ip_en_o, 3'b001);
    step(1'b0, 3'b111, 3'b001, 1'b0, 1'b0);
    check("mr_gnt_word0", bus.wr_gnt_o, 3'b001);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
